// File: rtl/instr_encoder.sv
// Assembles MIPS instruction words from one-hot class plus register/immediate fields
// and writes them to IMEM at an auto-incrementing word address (one write in flight).
module instr_encoder #(
  parameter int unsigned       ADDR_W    = 11,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              START,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [53:0]       OP_ONEHOT,
  input  logic [4:0]        RSC,
  input  logic [4:0]        RTC,
  input  logic [4:0]        RDC,
  input  logic [4:0]        SA,
  input  logic [15:0]       IMME,
  input  logic [25:0]       INDEX,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [31:0]       MEM_WDATA,
  input  logic              MEM_ACK,
  output logic              ERR,
  output logic              FULL,
  output logic [ADDR_W:0]   WORDS
);

  typedef enum logic {IDLE, WRITE} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              err_q, err_d;
  logic              full_q, full_d;
  logic [ADDR_W:0]   words_q, words_d;

  logic        legal;
  logic [4:0]  idx;
  logic [4:0]  rs, rt, rd, sa;
  logic [5:0]  func, opc;
  logic [31:0] enc_word;

  // Bits 31..53 of the one-hot vector are classes this encoder does not support.
  assign legal = $onehot(OP_ONEHOT[30:0]) && !(|OP_ONEHOT[53:31]);

  always_comb begin
    idx = '0;
    for (int unsigned i = 0; i < 31; i++) begin
      if (OP_ONEHOT[i]) idx = 5'(i);
    end
    rs       = RSC;
    rt       = RTC;
    rd       = RDC;
    sa       = '0;
    func     = '0;
    opc      = '0;
    enc_word = '0;
    if (idx <= 5'd16) begin
      case (idx)
        5'd0:    func = 6'b100000;
        5'd1:    func = 6'b100001;
        5'd2:    func = 6'b100010;
        5'd3:    func = 6'b100011;
        5'd4:    func = 6'b100100;
        5'd5:    func = 6'b100101;
        5'd6:    func = 6'b100110;
        5'd7:    func = 6'b100111;
        5'd8:    func = 6'b101010;
        5'd9:    func = 6'b101011;
        5'd10:   func = 6'b000000;
        5'd11:   func = 6'b000010;
        5'd12:   func = 6'b000011;
        5'd13:   func = 6'b000100;
        5'd14:   func = 6'b000110;
        5'd15:   func = 6'b000111;
        default: func = 6'b001000;
      endcase
      if (idx >= 5'd10 && idx <= 5'd12) begin
        sa = SA;
        rs = '0;
      end
      if (idx == 5'd16) begin
        rt = '0;
        rd = '0;
      end
      enc_word = {6'b000000, rs, rt, rd, sa, func};
    end else if (idx <= 5'd28) begin
      case (idx)
        5'd17:   opc = 6'b001000;
        5'd18:   opc = 6'b001001;
        5'd19:   opc = 6'b001100;
        5'd20:   opc = 6'b001101;
        5'd21:   opc = 6'b001110;
        5'd22:   opc = 6'b100011;
        5'd23:   opc = 6'b101011;
        5'd24:   opc = 6'b000100;
        5'd25:   opc = 6'b000101;
        5'd26:   opc = 6'b001010;
        5'd27:   opc = 6'b001011;
        default: opc = 6'b001111;
      endcase
      if (idx == 5'd28) rs = '0;
      enc_word = {opc, rs, rt, IMME};
    end else begin
      enc_word = {(idx == 5'd30) ? 6'b000011 : 6'b000010, INDEX};
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= IDLE;
      addr_q  <= BASE_ADDR;
      wdata_q <= '0;
      err_q   <= 1'b0;
      full_q  <= 1'b0;
      words_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      full_q  <= full_d;
      words_q <= words_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    full_d  = full_q;
    words_d = words_q;
    if (START) begin
      // START outranks a same-cycle ack: the pending write is dropped uncounted.
      state_d = IDLE;
      addr_d  = BASE_ADDR;
      err_d   = 1'b0;
      full_d  = 1'b0;
      words_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (IN_VALID && IN_READY) begin
            if (legal) begin
              state_d = WRITE;
              wdata_d = enc_word;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        WRITE: begin
          if (MEM_ACK) begin
            state_d = IDLE;
            words_d = words_q + (ADDR_W + 1)'(1);
            addr_d  = addr_q + ADDR_W'(1);
            if (addr_q == '1) full_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    IN_READY  = (state_q == IDLE) && !full_q && !START;
    MEM_WE    = (state_q == WRITE);
    MEM_ADDR  = addr_q;
    MEM_WDATA = wdata_q;
    ERR       = err_q;
    FULL      = full_q;
    WORDS     = words_q;
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: expected IMEM writes go into a scoreboard queue
// and a monitor pops them on every completed write handshake.
module tb_instr_encoder;

  localparam int unsigned AW = 2;

  logic          CLK, RSTN, START, IN_VALID, IN_READY;
  logic [53:0]   OP_ONEHOT;
  logic [4:0]    RSC, RTC, RDC, SA;
  logic [15:0]   IMME;
  logic [25:0]   INDEX;
  logic          MEM_WE, MEM_ACK, ERR, FULL;
  logic [AW-1:0] MEM_ADDR;
  logic [31:0]   MEM_WDATA;
  logic [AW:0]   WORDS;

  instr_encoder #(.ADDR_W(AW), .BASE_ADDR(2'd0)) dut (
    .CLK(CLK), .RSTN(RSTN), .START(START), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .OP_ONEHOT(OP_ONEHOT), .RSC(RSC), .RTC(RTC), .RDC(RDC), .SA(SA), .IMME(IMME),
    .INDEX(INDEX), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
    .MEM_ACK(MEM_ACK), .ERR(ERR), .FULL(FULL), .WORDS(WORDS)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [AW+31:0] sb[$];
  logic [AW-1:0]  exp_addr = '0;

  bit          ack_en    = 1'b1;
  bit          force_ack = 1'b0;
  int unsigned ack_delay = 0;
  int unsigned wcnt      = 0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic logic [53:0] oh(input int unsigned i);
    oh = 54'd1 << i;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // IMEM responder: acks after ack_delay cycles of MEM_WE, or drives force_ack when disabled.
  initial begin
    MEM_ACK = 1'b0;
    forever begin
      @(negedge CLK);
      if (!ack_en) begin
        MEM_ACK = force_ack;
      end else if (MEM_WE) begin
        if (wcnt >= ack_delay) begin
          MEM_ACK = 1'b1;
          wcnt    = 0;
        end else begin
          MEM_ACK = 1'b0;
          wcnt++;
        end
      end else begin
        MEM_ACK = 1'b0;
        wcnt    = 0;
      end
    end
  end

  // Monitor: a write completes on a cycle with MEM_WE & MEM_ACK and no START.
  initial begin
    logic [AW+31:0] e;
    forever begin
      @(negedge CLK);
      #1;
      if (RSTN && MEM_WE && MEM_ACK && !START) begin
        if (sb.size() == 0) begin
          check("unexpected_write", 64'(MEM_WDATA), 64'hDEAD_0000);
        end else begin
          e = sb.pop_front();
          check("wr_addr", 64'(MEM_ADDR), 64'(e[AW+31:32]));
          check("wr_data", 64'(MEM_WDATA), 64'(e[31:0]));
        end
      end
    end
  end

  task automatic send(input logic [53:0] op, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [4:0] sa, input logic [15:0] imm,
                      input logic [25:0] idx, input logic [31:0] exp_w, input bit push);
    int unsigned n = 0;
    @(negedge CLK);
    while (!IN_READY && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (!IN_READY) check("ready_timeout", 64'(IN_READY), 64'd1);
    OP_ONEHOT = op; RSC = rs; RTC = rt; RDC = rd; SA = sa; IMME = imm; INDEX = idx;
    IN_VALID  = 1'b1;
    if (push) begin
      sb.push_back({exp_addr, exp_w});
      exp_addr = exp_addr + AW'(1);
    end
    @(posedge CLK);
    #1 IN_VALID = 1'b0;
  endtask

  task automatic wait_idle();
    int unsigned n = 0;
    @(negedge CLK);
    while (MEM_WE && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (MEM_WE) check("ack_timeout", 64'(MEM_WE), 64'd0);
  endtask

  task automatic pulse_start();
    @(negedge CLK);
    START = 1'b1;
    #1 check("ready_during_start", 64'(IN_READY), 64'd0);
    @(posedge CLK);
    #1 START = 1'b0;
    exp_addr = '0;
  endtask

  initial begin
    RSTN = 1'b0; START = 1'b0; IN_VALID = 1'b0; OP_ONEHOT = '0;
    RSC = '0; RTC = '0; RDC = '0; SA = '0; IMME = '0; INDEX = '0;
    #3;
    check("rst_ready", 64'(IN_READY), 64'd1);
    check("rst_we", 64'(MEM_WE), 64'd0);
    check("rst_addr", 64'(MEM_ADDR), 64'd0);
    check("rst_wdata", 64'(MEM_WDATA), 64'd0);
    check("rst_err_full", 64'({ERR, FULL}), 64'd0);
    check("rst_words", 64'(WORDS), 64'd0);
    #17 RSTN = 1'b1;

    // ADD rs=1 rt=2 rd=3, single-cycle write
    send(oh(0), 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 32'h0022_1820, 1'b1);
    @(negedge CLK);
    check("add_we_latency1", 64'(MEM_WE), 64'd1);
    check("add_wdata", 64'(MEM_WDATA), 64'h0022_1820);
    wait_idle();
    check("add_words", 64'(WORDS), 64'd1);

    send(oh(17), 5'd0, 5'd8, 5'd9, 5'd0, 16'h0005, 26'h0, 32'h2008_0005, 1'b1);
    send(oh(22), 5'd29, 5'd31, 5'd0, 5'd0, 16'hFFFC, 26'h0, 32'h8FBF_FFFC, 1'b1);
    wait_idle();
    check("lw_words", 64'(WORDS), 64'd3);

    pulse_start();
    @(negedge CLK);
    check("start_words", 64'(WORDS), 64'd0);
    check("start_addr", 64'(MEM_ADDR), 64'd0);

    // SLL ignores RSC; JAL ignores register fields
    send(oh(10), 5'd7, 5'd2, 5'd4, 5'd3, 16'h0, 26'h0, 32'h0002_20C0, 1'b1);
    send(oh(30), 5'd5, 5'd6, 5'd7, 5'd8, 16'h1234, 26'h010_0000, 32'h0C10_0000, 1'b1);
    wait_idle();

    // OR with SA=9 (dropped), ack held off for 3 cycles
    ack_delay = 3;
    send(oh(5), 5'd4, 5'd5, 5'd6, 5'd9, 16'h0, 26'h0, 32'h0085_3025, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check("hold_we", 64'(MEM_WE), 64'd1);
      check("hold_addr", 64'(MEM_ADDR), 64'd2);
      check("hold_wdata", 64'(MEM_WDATA), 64'h0085_3025);
      check("hold_ready", 64'(IN_READY), 64'd0);
    end
    check("hold_words", 64'(WORDS), 64'd2);
    wait_idle();
    check("or_words", 64'(WORDS), 64'd3);
    ack_delay = 0;

    // illegal bundles are consumed without a write
    send(54'h3, 5'd1, 5'd1, 5'd1, 5'd0, 16'h0, 26'h0, 32'h0, 1'b0);
    @(negedge CLK);
    check("ill2_we", 64'(MEM_WE), 64'd0);
    check("ill2_err", 64'(ERR), 64'd1);
    check("ill2_addr", 64'(MEM_ADDR), 64'd3);
    check("ill2_ready", 64'(IN_READY), 64'd1);
    send(oh(40), 5'd1, 5'd1, 5'd1, 5'd0, 16'h0, 26'h0, 32'h0, 1'b0);
    @(negedge CLK);
    check("ill40_we", 64'(MEM_WE), 64'd0);
    check("ill40_words", 64'(WORDS), 64'd3);

    // JR forces rt/rd/sa to zero; last address sets FULL
    send(oh(16), 5'd31, 5'd5, 5'd6, 5'd7, 16'h0, 26'h0, 32'h03E0_0008, 1'b1);
    wait_idle();
    check("full_flag", 64'(FULL), 64'd1);
    check("full_ready", 64'(IN_READY), 64'd0);
    check("full_wrap_addr", 64'(MEM_ADDR), 64'd0);
    check("full_words", 64'(WORDS), 64'd4);
    check("full_err_sticky", 64'(ERR), 64'd1);

    pulse_start();
    @(negedge CLK);
    check("restart_flags", 64'({ERR, FULL, IN_READY}), 64'b001);

    // LUI forces rs=0
    send(oh(28), 5'd9, 5'd3, 5'd0, 5'd0, 16'h1234, 26'h0, 32'h3C03_1234, 1'b1);
    wait_idle();
    check("lui_words", 64'(WORDS), 64'd1);

    // START with a same-cycle ack drops the SW write
    send(oh(23), 5'd2, 5'd3, 5'd0, 5'd0, 16'h0010, 26'h0, 32'h0, 1'b0);
    ack_en = 1'b0; force_ack = 1'b1;
    @(negedge CLK);
    START = 1'b1;
    #1 check("sw_pending_wdata", 64'(MEM_WDATA), 64'hAC43_0010);
    @(posedge CLK);
    #1 START = 1'b0;
    exp_addr = '0;
    force_ack = 1'b0;
    check("drop_we", 64'(MEM_WE), 64'd0);
    check("drop_addr", 64'(MEM_ADDR), 64'd1 - 64'd1);
    check("drop_words", 64'(WORDS), 64'd0);

    // reset in the middle of a write
    send(oh(0), 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 32'h0, 1'b0);
    @(negedge CLK);
    check("prerst_we", 64'(MEM_WE), 64'd1);
    #2 RSTN = 1'b0;
    #1;
    check("async_we", 64'(MEM_WE), 64'd0);
    check("async_wdata", 64'(MEM_WDATA), 64'd0);
    @(negedge CLK);
    RSTN = 1'b1;
    ack_en = 1'b1;
    exp_addr = '0;

    // XOR after reset lands at address 0
    send(oh(6), 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 32'h0022_1826, 1'b1);
    wait_idle();
    check("final_words", 64'(WORDS), 64'd1);
    @(negedge CLK);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected end before 200000");
    $fatal(1);
  end

endmodule
